burst_master_port: RTL
======================

BURST_MASTER_PORT -- requirements
Module: burst_master_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, bus address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data beat width in bits.
REQ-003 SHALL have parameter LEN_WIDTH, default 4, burst-length field width; a burst is dlen+1 beats.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum read wait for svalid.
REQ-005 SHALL have ports: clk  in  1  single clock; rstn  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: daddr in ADDR_WIDTH start address; dmode in 1 0=read 1=write; dlen in LEN_WIDTH beats-1; dvalid in 1 command valid; dready out 1 command ready.
REQ-007 SHALL have ports: dwdata in DATA_WIDTH write beat; dwvalid in 1; dwready out 1; drdata out DATA_WIDTH read beat; drvalid out 1 read beat strobe; derr out 1 timeout pulse.
REQ-008 SHALL have ports: mwdata out 1 serial write bit; mmode out 1 frame mode; mvalid out 1 frame active; mrdata in 1 serial read bit; svalid in 1 slave read-data valid.

Function
REQ-009 SHALL accept a command only on a rising clk with dvalid=1 and dready=1; dready=1 only in IDLE.
REQ-010 SHALL use states IDLE, WGET, ADDR, WDATA, GAP, RWAIT, RDATA; IDLE->WGET (write) or ADDR (read) on accept.
REQ-011 SHALL in WGET drive dwready=1 and capture dwdata on dwvalid=1, then go to ADDR; mvalid=0 while waiting.
REQ-012 SHALL in ADDR drive mvalid=1, mmode=dmode latched, and shift beat address LSB-first over ADDR_WIDTH cycles.
REQ-013 SHALL for writes follow ADDR immediately with WDATA: DATA_WIDTH bits LSB-first, mvalid held 1, so a write frame is ADDR_WIDTH+DATA_WIDTH contiguous cycles.
REQ-014 SHALL for reads go ADDR->RWAIT with mvalid=0, then RDATA on first svalid=1, sampling mrdata LSB-first on each cycle svalid=1 until DATA_WIDTH bits collected.
REQ-015 SHALL pulse drvalid for exactly one cycle with the assembled beat in drdata, the cycle after the last bit is sampled; drdata holds until next beat.
REQ-016 SHALL insert GAP (one cycle, mvalid=0) after every beat; from GAP go to WGET/ADDR for next beat, or IDLE after beat dlen.
REQ-017 SHALL compute beat address as start+k modulo 2^ADDR_WIDTH (0xFFFF+1 wraps to 0x0000).
REQ-018 SHALL ignore dvalid, dwvalid and svalid in states where they are not consumed.
REQ-019 SHALL latch daddr, dmode and dlen at accept; later changes have no effect on the burst.
REQ-020 SHALL return dready=1 in the cycle after the final GAP.

Reset
REQ-021 SHALL on rstn=0, asynchronously: state IDLE, dready=1, dwready=0, drvalid=0, derr=0, mvalid=0, mmode=0, mwdata=0, drdata=0, counters 0.
REQ-022 SHALL abort any burst in progress on reset without completing or signalling it.

Configuration
REQ-023 SHALL with BURST_MASTER_TIMEOUT_EN defined count RWAIT cycles; at TIMEOUT_CYCLES without svalid, pulse derr one cycle, abandon remaining beats, go IDLE.
REQ-024 SHALL without BURST_MASTER_TIMEOUT_EN wait in RWAIT indefinitely; derr tied 0.

Structure
REQ-025 SHALL place the state enumeration and parameter defaults in package burst_master_pkg.
REQ-026 SHALL implement serialise/deserialise in one sub-module serial_shifter (parallel load, LSB-first shift out, shift in).

Verification
REQ-027 Single write daddr=0x0123 dwdata=0xA5 dlen=0 -> mvalid high 24 cycles, mwdata=0x0123 then 0xA5 LSB-first, mmode=1, dready returns.
REQ-028 Read burst daddr=0x0040 dlen=2, slave returns 0x11,0x22,0x33 -> three address frames 0x0040..0x0042, three drvalid pulses with those values.
REQ-029 Write burst daddr=0xFFFF dlen=1 -> frames at 0xFFFF then 0x0000.
REQ-030 Write with dwvalid delayed 5 cycles -> mvalid stays 0 for the delay, frame then sent unchanged.
REQ-031 Timeout build, read with svalid never high -> derr pulse after 255 RWAIT cycles, dready=1 next cycle; non-timeout build stays in RWAIT.
REQ-032 rstn low mid-WDATA -> all outputs at reset values immediately; new command after release completes normally.

Source files
------------

// File: rtl/burst_master_pkg.sv
// Shared definitions for the burst master port: parameter defaults and the
// controller state enumeration.
package burst_master_pkg;

    localparam int ADDR_WIDTH_DEF     = 16;
    localparam int DATA_WIDTH_DEF     = 8;
    localparam int LEN_WIDTH_DEF      = 4;
    localparam int TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WGET  = 3'd1,
        ADDR  = 3'd2,
        WDATA = 3'd3,
        GAP   = 3'd4,
        RWAIT = 3'd5,
        RDATA = 3'd6
    } state_e;

endpackage

// File: rtl/burst_master_port_serial_shifter.sv
// serial_shifter: parallel-load register that shifts toward bit 0, so the
// word leaves LSB-first on q_o[0] and serial input enters at the MSB.
module serial_shifter
    import burst_master_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] shreg_q;

    // Load has priority over shift so a new word can follow the last shift of the previous one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= load_val_i;
        end else if (shift_i) begin
            shreg_q <= {ser_i, shreg_q[WIDTH-1:1]};
        end
    end

    assign q_o = shreg_q;

endmodule

// File: rtl/burst_master_port.sv
// burst_master_port: converts parallel burst commands into serial bus frames.
// Each beat sends its address LSB-first; writes append the data beat in the
// same frame, reads wait for svalid-qualified serial data from the slave.
// Optional read timeout is enabled with `define BURST_MASTER_TIMEOUT_EN.
module burst_master_port
    import burst_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH      = LEN_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic                  dmode,
    input  logic [LEN_WIDTH-1:0]  dlen,
    input  logic                  dvalid,
    output logic                  dready,
    input  logic [DATA_WIDTH-1:0] dwdata,
    input  logic                  dwvalid,
    output logic                  dwready,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  drvalid,
    output logic                  derr,
    output logic                  mwdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  mrdata,
    input  logic                  svalid
);

    localparam int SH_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int BW   = $clog2(SH_W + 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  mode_q, mode_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
    logic                  drvalid_q, drvalid_d;

    logic                  tx_load, tx_shift, rx_shift;
    logic [SH_W-1:0]       tx_val, tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [ADDR_WIDTH-1:0] cur_addr, nxt_addr;
    logic                  timeout_hit;

    // Beat address wraps naturally at the address width.
    assign cur_addr = addr_q + ADDR_WIDTH'(beat_q);
    assign nxt_addr = cur_addr + ADDR_WIDTH'(1);

    serial_shifter #(.WIDTH(SH_W)) u_tx (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (tx_load),
        .load_val_i (tx_val),
        .shift_i    (tx_shift),
        .ser_i      (1'b0),
        .q_o        (tx_q)
    );

    serial_shifter #(.WIDTH(DATA_WIDTH)) u_rx (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (1'b0),
        .load_val_i ('0),
        .shift_i    (rx_shift),
        .ser_i      (mrdata),
        .q_o        (rx_q)
    );

`ifdef BURST_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Counts consecutive RWAIT cycles; cleared in every other state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // State and burst bookkeeping registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            mode_q    <= 1'b0;
            len_q     <= '0;
            beat_q    <= '0;
            bit_q     <= '0;
            wdata_q   <= '0;
            drdata_q  <= '0;
            drvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            bit_q     <= bit_d;
            wdata_q   <= wdata_d;
            drdata_q  <= drdata_d;
            drvalid_q <= drvalid_d;
        end
    end

    // Next-state logic and shifter control.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mode_d      = mode_q;
        len_d       = len_q;
        beat_d      = beat_q;
        bit_d       = bit_q;
        wdata_d     = wdata_q;
        drdata_d    = drdata_q;
        drvalid_d   = 1'b0;
        tx_load     = 1'b0;
        tx_val      = '0;
        tx_shift    = 1'b0;
        rx_shift    = 1'b0;
        timeout_hit = 1'b0;
`ifdef BURST_MASTER_TIMEOUT_EN
        to_cnt_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (dvalid) begin
                    addr_d = daddr;
                    mode_d = dmode;
                    len_d  = dlen;
                    beat_d = '0;
                    bit_d  = '0;
                    if (dmode) begin
                        state_d = WGET;
                    end else begin
                        tx_load = 1'b1;
                        tx_val  = SH_W'(daddr);
                        state_d = ADDR;
                    end
                end
            end
            WGET: begin
                if (dwvalid) begin
                    wdata_d = dwdata;
                    tx_load = 1'b1;
                    tx_val  = SH_W'(cur_addr);
                    bit_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                tx_shift = 1'b1;
                if (bit_q == BW'(ADDR_WIDTH - 1)) begin
                    bit_d = '0;
                    if (mode_q) begin
                        // Write data follows the last address bit with no gap.
                        tx_load = 1'b1;
                        tx_val  = SH_W'(wdata_q);
                        state_d = WDATA;
                    end else begin
                        state_d = RWAIT;
                    end
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            WDATA: begin
                tx_shift = 1'b1;
                if (bit_q == BW'(DATA_WIDTH - 1)) begin
                    bit_d   = '0;
                    state_d = GAP;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            RWAIT, RDATA: begin
                if (svalid) begin
                    rx_shift = 1'b1;
                    if (bit_q == BW'(DATA_WIDTH - 1)) begin
                        bit_d     = '0;
                        drdata_d  = {mrdata, rx_q[DATA_WIDTH-1:1]};
                        drvalid_d = 1'b1;
                        state_d   = GAP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = RDATA;
                    end
                end
`ifdef BURST_MASTER_TIMEOUT_EN
                else if (state_q == RWAIT) begin
                    if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_hit = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
`endif
            end
            GAP: begin
                if (beat_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                    if (mode_q) begin
                        state_d = WGET;
                    end else begin
                        tx_load = 1'b1;
                        tx_val  = SH_W'(nxt_addr);
                        state_d = ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dready  = (state_q == IDLE);
    assign dwready = (state_q == WGET);
    assign mvalid  = (state_q == ADDR) || (state_q == WDATA);
    assign mmode   = mvalid & mode_q;
    assign mwdata  = mvalid & tx_q[0];
    assign drdata  = drdata_q;
    assign drvalid = drvalid_q;
    assign derr    = timeout_hit;

    logic unused_bits;
    assign unused_bits = ^{tx_q[SH_W-1:1], rx_q[0]};

endmodule
